// File: rtl/disp_hold_queue_pkg.sv
// Shared defaults and FSM encoding for the display hold queue.
package disp_hold_queue_pkg;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_DWELL     = 50_000_000;
  localparam int DEF_TURBO_DIV = 4;

  typedef enum logic {IDLE = 1'b0, SHOW = 1'b1} state_t;
endpackage

// File: rtl/disp_hold_queue_sync_fifo.sv
// Small synchronous FIFO with wrapping pointers and an occupancy count.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_W-1:0]       wdata,
  output logic [DATA_W-1:0]       rdata,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage is not reset: pointer reset alone discards old contents.
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/disp_hold_queue.sv
// Buffers 8-bit values and shows each on data_out for a fixed dwell time,
// shortened in turbo mode; feeds disp_hex.
module disp_hold_queue
  import disp_hold_queue_pkg::*;
#(
  parameter int DEPTH        = DEF_DEPTH,
  parameter int DWELL_CYCLES = DEF_DWELL,
  parameter int TURBO_DIV    = DEF_TURBO_DIV
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   turbo_mode,
  output logic [7:0]             data_out,
  output logic                   turbo_out,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count
);
  localparam int CW = $clog2(DWELL_CYCLES);
  localparam logic [CW-1:0] NORM_LD  = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] TURBO_LD = CW'(DWELL_CYCLES / TURBO_DIV - 1);

  state_t        state;
  logic [CW-1:0] dwell;
  logic [CW-1:0] load;
  logic [7:0]    head;
  logic          full, empty, pop;

  sync_fifo #(.DATA_W(8), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (pop),
    .wdata (in_data),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign in_ready = ~full;
  assign load     = turbo_mode ? TURBO_LD : NORM_LD;
  // A pop happens on leaving IDLE or at dwell expiry, never mid-dwell.
  assign pop      = ~empty && (state == IDLE || dwell == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dwell     <= '0;
      data_out  <= '0;
      busy      <= 1'b0;
      turbo_out <= 1'b0;
    end else begin
      turbo_out <= turbo_mode;
      case (state)
        IDLE: if (pop) begin
          data_out <= head;
          dwell    <= load;
          busy     <= 1'b1;
          state    <= SHOW;
        end
        SHOW: begin
          if (dwell == '0) begin
            if (pop) begin
              data_out <= head;
              dwell    <= load;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else if (turbo_mode && dwell > TURBO_LD) begin
            dwell <= TURBO_LD;
          end else begin
            dwell <= dwell - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_disp_hold_queue.sv
// Randomized + directed bench for disp_hold_queue against a queue-based model.
module tb_disp_hold_queue;
  localparam int DEPTH = 4, DW = 8, TDIV = 4, TL = DW / TDIV - 1;

  logic       clk = 0, rst = 1;
  logic [7:0] in_data = 0;
  logic       in_valid = 0, turbo_mode = 0;
  logic       in_ready, turbo_out, busy;
  logic [7:0] data_out;
  logic [2:0] count;

  int total = 0, bad = 0;

  disp_hold_queue #(.DEPTH(DEPTH), .DWELL_CYCLES(DW), .TURBO_DIV(TDIV)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .turbo_mode(turbo_mode), .data_out(data_out),
    .turbo_out(turbo_out), .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  // Model: a queue of pending values plus the value on show and the
  // number of further clocks it stays up.
  int         mq[$];
  logic [7:0] m_data = 0;
  bit         m_busy = 0, m_turbo = 0, m_acc, m_t;
  int         m_rem = 0;
  logic [7:0] m_d;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete(); m_data = 0; m_busy = 0; m_rem = 0; m_turbo = 0;
    end else begin
      m_acc = in_valid && mq.size() < DEPTH;
      m_d = in_data;
      m_t = turbo_mode;
      if (!m_busy) begin
        if (mq.size() > 0) begin
          m_data = 8'(mq.pop_front()); m_busy = 1; m_rem = m_t ? TL : DW - 1;
        end
      end else if (m_rem == 0) begin
        if (mq.size() > 0) begin
          m_data = 8'(mq.pop_front()); m_rem = m_t ? TL : DW - 1;
        end else m_busy = 0;
      end else begin
        m_rem = (m_t && m_rem > TL) ? TL : m_rem - 1;
      end
      if (m_acc) mq.push_back(int'(m_d));
      m_turbo = m_t;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("m.data_out", int'(data_out), int'(m_data));
      chk("m.busy", int'(busy), int'(m_busy));
      chk("m.count", int'(count), mq.size());
      chk("m.in_ready", int'(in_ready), int'(mq.size() < DEPTH));
      chk("m.turbo_out", int'(turbo_out), int'(m_turbo));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, ".data_out"}, int'(data_out), 0);
    chk({tag, ".busy"}, int'(busy), 0);
    chk({tag, ".count"}, int'(count), 0);
    chk({tag, ".in_ready"}, int'(in_ready), 1);
    chk({tag, ".turbo_out"}, int'(turbo_out), 0);
  endtask

  logic [7:0] vals [6];
  logic [7:0] shown [$];
  logic [7:0] last_d;
  bit         last_b, acc_pre;
  int         idx, pct;

  initial begin
    vals = '{8'h00, 8'h0D, 8'h1A, 8'h27, 8'h34, 8'h41};
    // 1: reset state
    turbo_mode = 1;
    repeat (3) step();
    reset_checks("rst");
    turbo_mode = 0;
    rst = 0;
    step();

    // 2: single value, 8-cycle dwell
    in_data = 8'h2A; in_valid = 1;
    step();                       // edge N
    in_valid = 0;
    chk("t2.count_n", int'(count), 1);
    chk("t2.data_n", int'(data_out), 0);
    step();                       // N+1
    chk("t2.data", int'(data_out), 8'h2A);
    chk("t2.hi", int'(data_out[7:4]), 2);
    chk("t2.lo", int'(data_out[3:0]), 4'hA);
    for (int k = 0; k < 7; k++) begin
      step();
      chk("t2.busy_hold", int'(busy), 1);
    end
    step();
    chk("t2.busy_end", int'(busy), 0);
    chk("t2.data_keep", int'(data_out), 8'h2A);
    step();

    // 3 + 6: burst with in_valid held, push blocked while full
    idx = 0; in_data = vals[0]; in_valid = 1; last_b = 0; last_d = data_out;
    for (int s = 1; s <= 70; s++) begin
      acc_pre = in_valid && in_ready;
      step();
      if (acc_pre) idx++;
      if (idx < 6) in_data = vals[idx]; else in_valid = 0;
      if (busy && (!last_b || data_out != last_d)) shown.push_back(data_out);
      last_b = busy; last_d = data_out;
      if (s == 5) begin
        chk("t3.full_count", int'(count), 4);
        chk("t3.full_rdy", int'(in_ready), 0);
      end
      if (s == 10) begin
        chk("t6.pop_count", int'(count), 3);
        chk("t6.pop_rdy", int'(in_ready), 1);
        chk("t6.pop_data", int'(data_out), 8'h0D);
      end
      if (s == 11) chk("t6.refill", int'(count), 4);
    end
    chk("t3.nshown", shown.size(), 6);
    for (int k = 0; k < 6; k++)
      chk("t3.order", (k < shown.size()) ? int'(shown[k]) : -1, int'(vals[k]));

    // 4: turbo mid-dwell clamps the counter
    in_data = 8'hA1; in_valid = 1;
    step();                       // A1 accepted
    in_data = 8'hB2;
    step();                       // A1 shown, B2 accepted
    in_valid = 0;
    chk("t4.a1", int'(data_out), 8'hA1);
    step(); step();               // 5 dwell cycles remain
    turbo_mode = 1;
    step();
    chk("t4.tout", int'(turbo_out), 1);
    chk("t4.a1_clamp", int'(data_out), 8'hA1);
    step();
    chk("t4.a1_last", int'(data_out), 8'hA1);
    step();
    chk("t4.b2", int'(data_out), 8'hB2);
    step();
    chk("t4.b2_busy", int'(busy), 1);
    step();
    chk("t4.b2_done", int'(busy), 0);
    turbo_mode = 0;
    step();
    chk("t4.tout_off", int'(turbo_out), 0);

    // 5: asynchronous reset mid-dwell with three queued
    in_valid = 1;
    for (int k = 0; k < 4; k++) begin
      in_data = 8'hC0 + 8'(k);
      step();
    end
    in_valid = 0;
    step();
    chk("t5.pre_count", int'(count), 3);
    #2 rst = 1;
    #1 reset_checks("t5");
    step();
    rst = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("t5.no_old", int'(data_out), 0);
    end

    // randomized traffic
    pct = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 300 == 0) pct = $urandom_range(5, 95);
      if ($urandom_range(0, 149) == 0) turbo_mode = ~turbo_mode;
      in_valid = $urandom_range(0, 99) < pct;
      in_data = 8'($urandom);
      if (i == 1500) begin
        #2 rst = 1;
        #1 reset_checks("rnd_rst");
        step();
        rst = 0;
      end
      step();
    end
    in_valid = 0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
